spi_apb_bridge: RTL and testbench

SPI_APB_BRIDGE -- requirements
Module: spi_apb_bridge

---
 rtl/spi_apb_bridge.sv | 242 ++++++++++++++++++++++++
 tb/tb_spi_apb_bridge.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_bridge.sv
// SPI slave (mode 0, 2-byte frames) that turns each frame into a single APB read or write.
// The SPI inputs are sampled and synchronized into the pclk domain. A timeout on pready sets a sticky error flag.
`timescale 1ns/1ps
module spi_apb_bridge #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic                  psel,
  output logic                  penable,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  output logic                  busy,
  output logic                  err
);

  localparam int FRAME_BITS = 2 * DATA_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam int TMO_W      = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} apb_state_e;

  // ---------------- synchronizers and edge detection ----------------
  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, settle_q;
  logic       sclk_prev_q, cs_prev_q, armed_q;
  logic       sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      settle_q    <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs_n};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_sync_q[1];
      cs_prev_q   <= cs_sync_q[1];
      settle_q    <= {settle_q[0], 1'b1};
      // A frame may only start once cs_n has really been seen high after reset.
      armed_q     <= armed_q | (settle_q[1] & cs_sync_q[1]);
    end
  end

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // ---------------- SPI frame receive / transmit ----------------
  logic                  frame_q, cmd_rd_q, cmd_wr_q, read_live_q, miso_q, err_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [DATA_WIDTH-1:0] rx_q, tx_q, rx_next;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic                  bit_take, byte0_done, byte1_done, new_rd, new_wr, new_req;
  logic [ADDR_WIDTH-1:0] new_addr;
  logic                  done_ok, done_tmo, rd_done;

  assign bit_take   = sclk_rise & frame_q & ~cs_s & (bit_cnt_q < CNT_W'(FRAME_BITS));
  assign rx_next    = {rx_q[DATA_WIDTH-2:0], mosi_s};
  assign byte0_done = bit_take & (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign byte1_done = bit_take & (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
  assign new_rd     = byte0_done & ~rx_next[DATA_WIDTH-1];
  assign new_wr     = byte1_done & cmd_wr_q;
  assign new_req    = new_rd | new_wr;
  assign new_addr   = new_rd ? rx_next[ADDR_WIDTH-1:0] : cmd_addr_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      frame_q     <= 1'b0;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_rd_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      cmd_addr_q  <= '0;
      read_live_q <= 1'b0;
      miso_q      <= 1'b0;
    end else if (cs_fall) begin
      frame_q     <= 1'b1;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cmd_rd_q    <= 1'b0;
      cmd_wr_q    <= 1'b0;
      read_live_q <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      if (cs_rise) begin
        frame_q     <= 1'b0;
        read_live_q <= 1'b0;
      end
      if (bit_take) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        rx_q      <= rx_next;
        if (byte0_done) begin
          cmd_wr_q    <= rx_next[DATA_WIDTH-1];
          cmd_rd_q    <= ~rx_next[DATA_WIDTH-1];
          cmd_addr_q  <= rx_next[ADDR_WIDTH-1:0];
          read_live_q <= ~rx_next[DATA_WIDTH-1];
        end
      end
      // Read data goes out during the second byte only; everything else shifts zeros.
      if (cs_s) begin
        miso_q <= 1'b0;
      end else if (sclk_fall && frame_q) begin
        if (cmd_rd_q && bit_cnt_q >= CNT_W'(DATA_WIDTH) && bit_cnt_q < CNT_W'(FRAME_BITS)) begin
          miso_q <= tx_q[DATA_WIDTH-1];
          tx_q   <= {tx_q[DATA_WIDTH-2:0], 1'b0};
        end else begin
          miso_q <= 1'b0;
        end
      end
      if (rd_done && read_live_q) tx_q <= done_tmo ? '0 : prdata;
    end
  end

  assign miso = miso_q & ~cs_s;

  // ---------------- APB master FSM ----------------
  apb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d, req_addr_q, req_addr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d, req_data_q, req_data_d;
  logic                  pwrite_q, pwrite_d, req_pend_q, req_pend_d, req_wr_q, req_wr_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  pend_live, new_taken;

  // A queued read belongs to a frame that just ended early; drop it. Queued writes still go out.
  assign pend_live = req_pend_q & ~(cs_rise & ~req_wr_q);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    tmo_d      = tmo_q;
    req_pend_d = pend_live;
    req_wr_d   = req_wr_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    done_ok    = 1'b0;
    done_tmo   = 1'b0;
    new_taken  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_live) begin
          state_d    = S_SETUP;
          paddr_d    = req_addr_q;
          pwrite_d   = req_wr_q;
          if (req_wr_q) pwdata_d = req_data_q;
          req_pend_d = 1'b0;
        end else if (new_req) begin
          state_d   = S_SETUP;
          paddr_d   = new_addr;
          pwrite_d  = new_wr;
          if (new_wr) pwdata_d = rx_next;
          new_taken = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        tmo_d   = '0;
      end
      S_ACCESS: begin
        if (pready) begin
          done_ok = 1'b1;
          state_d = S_IDLE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          done_tmo = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A request arriving while a transfer is running waits here until IDLE.
    if (new_req && !new_taken) begin
      req_pend_d = 1'b1;
      req_wr_d   = new_wr;
      req_addr_d = new_addr;
      req_data_d = rx_next;
    end
  end

  assign rd_done = (done_ok | done_tmo) & ~pwrite_q;

  // NOTE: every register here is reset; there is no memory array, so nothing is left unreset.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= S_IDLE;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      tmo_q      <= '0;
      req_pend_q <= 1'b0;
      req_wr_q   <= 1'b0;
      req_addr_q <= '0;
      req_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      tmo_q      <= tmo_d;
      req_pend_q <= req_pend_d;
      req_wr_q   <= req_wr_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      if (done_tmo)     err_q <= 1'b1;
      else if (cs_fall) err_q <= 1'b0;
    end
  end

  assign psel    = (state_q != S_IDLE);
  assign penable = (state_q == S_ACCESS);
  assign pwrite  = pwrite_q & psel;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign busy    = psel;
  assign err     = err_q;

endmodule

// File: tb/tb_spi_apb_bridge.sv
// Directed bench for spi_apb_bridge: an SPI master drives frames and a small APB slave memory responds.
// Observed APB activity and miso bits are compared against hand-computed values.
`timescale 1ns/1ps
module tb_spi_apb_bridge;
  localparam int HALF = 100;  // sclk half period: 10 pclk cycles

  logic       pclk, presetn, sclk, cs_n, mosi, miso;
  logic [2:0] paddr;
  logic       pwrite, psel, penable, pready, busy, err;
  logic [7:0] pwdata, prdata;
  logic       ready_en;
  logic [7:0] mem [0:7] = '{8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  int n_vec = 0, n_err = 0;
  int n_xfer = 0, cur_acc = 0, last_acc = 0, unstable = 0, busy_bad = 0;
  int xfer_at7 = 0, xfer_at8 = 0;
  logic [2:0] setup_addr, last_addr;
  logic [7:0] setup_data, last_data;
  logic       setup_wr, last_wr;

  spi_apb_bridge #(.ADDR_WIDTH(3), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .pclk(pclk), .presetn(presetn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .busy(busy), .err(err)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  assign pready = ready_en & psel & penable;
  assign prdata = mem[paddr];

  always @(posedge pclk)
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;

  // APB monitor, sampled on the falling edge.
  always @(negedge pclk) begin
    if (busy !== psel || (penable && !psel)) busy_bad++;
    if (psel && !penable) begin
      n_xfer++;
      cur_acc    = 0;
      setup_addr = paddr;
      setup_data = pwdata;
      setup_wr   = pwrite;
    end
    if (psel && penable) begin
      cur_acc++;
      last_acc  = cur_acc;
      last_addr = paddr;
      last_data = pwdata;
      last_wr   = pwrite;
      if (paddr !== setup_addr || pwdata !== setup_data || pwrite !== setup_wr) unstable++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    #HALF;
    m = miso;
    sclk = 1'b1;
    #HALF;
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [23:0] tx, input int nbits, output logic [23:0] rx);
    logic m;
    rx = '0;
    cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      if (i == 7) xfer_at7 = n_xfer;
      if (i == 8) xfer_at8 = n_xfer;
      spi_bit(tx[23-i], m);
      rx[23-i] = m;
    end
    #HALF;
    cs_n = 1'b1;
    #HALF;
  endtask

  initial begin
    logic [23:0] rx;
    logic        m;
    int          base, k;
    presetn = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; ready_en = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    presetn = 1'b1;
    repeat (5) @(negedge pclk);

    // Write 0x83, 0x5A: one write to address 3, one SETUP + one ACCESS cycle.
    base = n_xfer;
    spi_frame({8'h83, 8'h5A, 8'h00}, 16, rx);
    repeat (5) @(negedge pclk);
    check("wr_count", n_xfer - base, 1);
    check("wr_addr", last_addr, 3);
    check("wr_data", last_data, 8'h5A);
    check("wr_dir", last_wr, 1);
    check("wr_access_len", last_acc, 1);
    check("wr_err", err, 0);
    check("wr_miso", rx, 0);
    check("wr_mem", mem[3], 8'h5A);
    check("wr_idle_psel", psel, 0);
    check("wr_hold_pwdata", pwdata, 8'h5A);

    // Read 0x01: transfer starts after bit 8, data 0xC3 shifts out during byte 1.
    base = n_xfer;
    spi_frame({8'h01, 8'h00, 8'h00}, 16, rx);
    repeat (5) @(negedge pclk);
    check("rd_not_before_b8", xfer_at7 - base, 0);
    check("rd_after_b8", xfer_at8 - base, 1);
    check("rd_count", n_xfer - base, 1);
    check("rd_addr", last_addr, 1);
    check("rd_dir", last_wr, 0);
    check("rd_miso", rx[23:8], 16'h00C3);
    check("rd_hold_pwdata", pwdata, 8'h5A);

    // 20-bit read of address 3: extra bits give no transfer and shift zeros.
    base = n_xfer;
    spi_frame({8'h03, 8'h00, 8'hF0}, 20, rx);
    repeat (5) @(negedge pclk);
    check("long_count", n_xfer - base, 1);
    check("long_miso", rx, 24'h005A00);

    // 20-bit write: still exactly one transfer.
    base = n_xfer;
    spi_frame({8'h86, 8'h22, 8'hFF}, 20, rx);
    repeat (5) @(negedge pclk);
    check("long_wr_count", n_xfer - base, 1);
    check("long_wr_data", last_data, 8'h22);
    check("long_wr_miso", rx, 0);

    // Timeout: pready held low, ACCESS lasts 15 cycles, err set.
    ready_en = 1'b0;
    base = n_xfer;
    spi_frame({8'h82, 8'h33, 8'h00}, 16, rx);
    repeat (30) @(negedge pclk);
    check("tmo_count", n_xfer - base, 1);
    check("tmo_access_len", last_acc, 15);
    check("tmo_psel", psel, 0);
    check("tmo_err", err, 1);
    ready_en = 1'b1;

    // Next frame clears err at cs_n fall; aborted after 12 bits, so no write.
    base = n_xfer;
    cs_n = 1'b0;
    #HALF;
    check("err_clear", err, 0);
    for (int i = 0; i < 12; i++) begin
      logic [15:0] w;
      w = 16'h8477;
      spi_bit(w[15-i], m);
    end
    #HALF;
    cs_n = 1'b1;
    #HALF;
    repeat (20) @(negedge pclk);
    check("abort_no_xfer", n_xfer - base, 0);

    spi_frame({8'h85, 8'h66, 8'h00}, 16, rx);
    repeat (5) @(negedge pclk);
    check("after_abort_count", n_xfer - base, 1);
    check("after_abort_addr", last_addr, 5);
    check("after_abort_data", last_data, 8'h66);

    // Reset pulse during ACCESS drops psel/penable/busy immediately.
    ready_en = 1'b0;
    cs_n = 1'b0;
    #HALF;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'h8199;
      spi_bit(w[15-i], m);
    end
    k = 0;
    while (!(psel && penable) && k < 50) begin
      @(negedge pclk);
      k++;
    end
    check("rst_mid_access_reached", {psel, penable}, 2'b11);
    #3;
    presetn = 1'b0;
    #1;
    check("rst_async_psel", psel, 0);
    check("rst_async_penable", penable, 0);
    check("rst_async_busy", busy, 0);
    @(negedge pclk);
    presetn = 1'b1;
    ready_en = 1'b1;
    base = n_xfer;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      w = 16'h8144;
      spi_bit(w[15-i], m);
    end
    #HALF;
    cs_n = 1'b1;
    #HALF;
    repeat (20) @(negedge pclk);
    check("rst_no_xfer", n_xfer - base, 0);
    check("rst_err_low", err, 0);

    spi_frame({8'h87, 8'h44, 8'h00}, 16, rx);
    repeat (5) @(negedge pclk);
    check("post_rst_count", n_xfer - base, 1);
    check("post_rst_addr", last_addr, 7);

    // Back-to-back write 0x80/0x11 then read address 0.
    spi_frame({8'h80, 8'h11, 8'h00}, 16, rx);
    spi_frame({8'h00, 8'h00, 8'h00}, 16, rx);
    repeat (5) @(negedge pclk);
    check("b2b_read_miso", rx[15:8], 8'h11);
    check("b2b_read_addr", last_addr, 0);

    check("busy_matches_psel", busy_bad, 0);
    check("apb_stable", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
